// File: rtl/fixed_point_rescaler_pkg.sv
// Shared constants and types for the fixed-point rescaler and its companion divider.
package fixed_point_rescaler_pkg;

  localparam int unsigned FRAC_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Half an LSB of the integer result, expressed in fractional units.
  function automatic int unsigned round_half(input int unsigned frac);
    return (frac == 0) ? 0 : (32'd1 << (frac - 1));
  endfunction

  localparam int unsigned ROUND_HALF = round_half(FRAC_DEFAULT);

endpackage

// File: rtl/fixed_point_rescaler_mul_core.sv
// Sequential shift-add multiplier: one bit of the multiplier per enabled clock, LSB first.
module fixed_point_rescaler_mul_core #(
  parameter int unsigned Q_W = 16,
  parameter int unsigned B_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_en,
  input  logic [Q_W-1:0]       i_q,
  input  logic [B_W-1:0]       i_b,
  output logic                 o_done,
  output logic [Q_W+B_W-1:0]   o_acc_next
);

  localparam int unsigned P_W   = Q_W + B_W;
  localparam int unsigned CNT_W = (B_W > 1) ? $clog2(B_W) : 1;

  logic [P_W-1:0]   r_mcand;
  logic [B_W-1:0]   r_mult;
  logic [P_W-1:0]   r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [P_W-1:0]   w_acc_next;

  // The accumulator value after this step is exported so the final sum can be
  // registered on the same edge the last partial product is added.
  always_comb begin
    w_acc_next = r_mult[0] ? (r_acc + r_mcand) : r_acc;
  end

  assign o_acc_next = w_acc_next;
  assign o_done     = i_en && (r_cnt == CNT_W'(B_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand <= '0;
      r_mult  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_mcand <= P_W'(i_q);
      r_mult  <= i_b;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (i_en) begin
      r_acc   <= w_acc_next;
      r_mcand <= r_mcand << 1;
      r_mult  <= r_mult >> 1;
      r_cnt   <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fixed_point_rescaler.sv
// Rescales a fixed-point ratio back to an integer: a = round(q*b / 2^FRAC), saturated.
module fixed_point_rescaler
  import fixed_point_rescaler_pkg::*;
#(
  parameter int unsigned Q_W   = 16,
  parameter int unsigned B_W   = 8,
  parameter int unsigned FRAC  = FRAC_DEFAULT,
  parameter int unsigned ROUND = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [Q_W-1:0] q,
  input  logic [B_W-1:0] b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [B_W-1:0] a,
  output logic           sat
);

  localparam int unsigned P_W = Q_W + B_W;
  localparam logic [P_W:0] RND_BIAS = (ROUND != 0) ? (P_W + 1)'(round_half(FRAC)) : '0;

  state_t         r_state;
  state_t         w_state_next;
  logic [B_W-1:0] r_a;
  logic           r_sat;
  logic           w_accept;
  logic           w_busy;
  logic           w_done;
  logic [P_W-1:0] w_acc_next;
  logic [P_W:0]   w_p;
  logic [P_W:0]   w_r;
  logic           w_clip;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign a         = r_a;
  assign sat       = r_sat;
  assign w_accept  = in_valid && in_ready;
  assign w_busy    = (r_state == BUSY);

  fixed_point_rescaler_mul_core #(
    .Q_W (Q_W),
    .B_W (B_W)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_accept),
    .i_en       (w_busy),
    .i_q        (q),
    .i_b        (b),
    .o_done     (w_done),
    .o_acc_next (w_acc_next)
  );

  // One extra bit keeps the rounding add from wrapping on the largest product.
  always_comb begin
    w_p    = {1'b0, w_acc_next} + RND_BIAS;
    w_r    = w_p >> FRAC;
    w_clip = |w_r[P_W:B_W];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = BUSY;
      BUSY:    if (w_done)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_busy && w_done) begin
        r_a   <= w_clip ? '1 : w_r[B_W-1:0];
        r_sat <= w_clip;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_rescaler.sv
// Directed bench for fixed_point_rescaler, rounding and truncating builds side by side.
module tb_fixed_point_rescaler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] q = '0;
  logic [7:0]  b = '0;
  logic        out_ready = 1'b1;

  logic        in_ready1, out_valid1, sat1;
  logic [7:0]  a1;
  logic        in_ready0, out_valid0, sat0;
  logic [7:0]  a0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fixed_point_rescaler #(.Q_W(16), .B_W(8), .FRAC(8), .ROUND(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .q(q), .b(b),
    .out_valid(out_valid1), .out_ready(out_ready), .a(a1), .sat(sat1)
  );

  fixed_point_rescaler #(.Q_W(16), .B_W(8), .FRAC(8), .ROUND(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .q(q), .b(b),
    .out_valid(out_valid0), .out_ready(out_ready), .a(a0), .sat(sat0)
  );

  // Reference result as {sat, a} from plain integer arithmetic.
  function automatic bit [8:0] expect_res(input bit [15:0] fq, input bit [7:0] fb, input bit rnd);
    longint p;
    longint r;
    p = longint'(fq) * longint'(fb) + (rnd ? 128 : 0);
    r = p / 256;
    if (r > 255) return {1'b1, 8'hFF};
    return {1'b0, r[7:0]};
  endfunction

  // Transaction-level model: accept when idle, result appears 8 edges later,
  // held until the consumer takes it.
  int       m_left = 0;
  bit       m_outv = 1'b0;
  bit [15:0] m_q = '0;
  bit [7:0]  m_b = '0;
  bit [8:0]  m_r1 = '0;
  bit [8:0]  m_r0 = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left <= 0;
      m_outv <= 1'b0;
      m_r1   <= '0;
      m_r0   <= '0;
    end else if (m_outv) begin
      if (out_ready) m_outv <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_outv <= 1'b1;
        m_r1   <= expect_res(m_q, m_b, 1'b1);
        m_r0   <= expect_res(m_q, m_b, 1'b0);
      end
    end else if (in_valid) begin
      m_left <= 8;
      m_q    <= q;
      m_b    <= b;
    end
  end

  // Hand-computed expectations for the directed cases, and the round-trip target.
  bit       lit_on = 1'b0;
  bit [8:0] lit_r1 = '0;
  bit [8:0] lit_r0 = '0;
  bit       rt_on = 1'b0;
  int       rt_a = 0;
  int       nr_run = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit exp_rdy;
    exp_rdy = !m_outv && (m_left == 0);
    chk("in_ready_r1",  int'(in_ready1),  int'(exp_rdy));
    chk("out_valid_r1", int'(out_valid1), int'(m_outv));
    chk("a_r1",         int'(a1),         int'(m_r1[7:0]));
    chk("sat_r1",       int'(sat1),       int'(m_r1[8]));
    chk("in_ready_r0",  int'(in_ready0),  int'(exp_rdy));
    chk("out_valid_r0", int'(out_valid0), int'(m_outv));
    chk("a_r0",         int'(a0),         int'(m_r0[7:0]));
    chk("sat_r0",       int'(sat0),       int'(m_r0[8]));
    if (in_ready1) nr_run = 0; else nr_run++;
    chk("not_ready_watchdog", int'(nr_run > 30), 0);
    if (lit_on && out_valid1) begin
      chk("lit_r1", int'({sat1, a1}), int'(lit_r1));
      chk("lit_r0", int'({sat0, a0}), int'(lit_r0));
      chk("lit_model_r1", int'(m_r1), int'(lit_r1));
      chk("lit_model_r0", int'(m_r0), int'(lit_r0));
    end
    if (rt_on && out_valid1) begin
      chk("roundtrip_r1", int'(int'(a1) >= rt_a - 1 && int'(a1) <= rt_a && !sat1), 1);
      chk("roundtrip_r0", int'(int'(a0) >= rt_a - 1 && int'(a0) <= rt_a && !sat0), 1);
    end
  end

  task automatic op(input logic [15:0] tq, input logic [7:0] tb_, input int hold);
    q = tq;
    b = tb_;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    q = 16'hA5A5;
    b = 8'h5A;
    for (int i = 0; i < 20 && !out_valid1; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      q = 16'h1234;
      b = 8'h56;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic lit_op(input logic [15:0] tq, input logic [7:0] tb_, input bit [8:0] r1,
                        input bit [8:0] r0, input int hold);
    lit_r1 = r1;
    lit_r0 = r0;
    lit_on = 1'b1;
    op(tq, tb_, hold);
    lit_on = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    lit_op(16'h0180, 8'd100, {1'b0, 8'd150}, {1'b0, 8'd150}, 0);
    lit_op(16'h0080, 8'd3,   {1'b0, 8'd2},   {1'b0, 8'd1},   0);
    lit_op(16'hFFFF, 8'd255, {1'b1, 8'd255}, {1'b1, 8'd255}, 0);
    lit_op(16'h0100, 8'd255, {1'b0, 8'd255}, {1'b0, 8'd255}, 0);
    lit_op(16'hFFFF, 8'd0,   {1'b0, 8'd0},   {1'b0, 8'd0},   0);
    lit_op(16'h0100, 8'd200, {1'b0, 8'd200}, {1'b0, 8'd200}, 0);
    lit_op(16'h0000, 8'd255, {1'b0, 8'd0},   {1'b0, 8'd0},   0);
    lit_op(16'h0240, 8'd7,   {1'b0, 8'd16},  {1'b0, 8'd15},  5);
    lit_op(16'h0180, 8'd100, {1'b0, 8'd150}, {1'b0, 8'd150}, 2);

    // Abort in the middle of a multiply; nothing from it may ever appear.
    q = 16'h0180;
    b = 8'd100;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    lit_op(16'h0100, 8'd77, {1'b0, 8'd77}, {1'b0, 8'd77}, 0);

    rt_on = 1'b1;
    for (int bb = 1; bb < 256; bb += 13) begin
      for (int aa = 0; aa < bb; aa += 5) begin
        rt_a = aa;
        op(16'((aa << 8) / bb), 8'(bb), 0);
      end
    end
    rt_on = 1'b0;

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
